// File: rtl/chu_video_pkg.sv
// Shared definitions for the video daisy-chain cores: register offsets,
// ctrl bit positions, default screen size, the coordinate type and the
// per-axis motion/bounce step used by the animated sprite core.
package chu_video_pkg;

  // 11-bit frame-counter coordinate
  typedef logic [10:0] coord_t;

  // Default visible area
  localparam int H_MAX_DEF = 640;
  localparam int V_MAX_DEF = 480;

  // Register offsets, decoded on addr[2:0] when addr[13]=1
  localparam logic [2:0] REG_BYPASS = 3'd0;
  localparam logic [2:0] REG_X0     = 3'd1;
  localparam logic [2:0] REG_Y0     = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_PERIOD = 3'd4;
  localparam logic [2:0] REG_VEL    = 3'd5;

  // ctrl register bit positions
  localparam int CTRL_ANIM_EN   = 0;
  localparam int CTRL_MOTION_EN = 1;
  localparam int CTRL_FRAME_LSB = 2;
  localparam int CTRL_H_MIRROR  = 7;

  // Result of one motion step on one axis
  typedef struct packed {
    coord_t     pos;
    logic [3:0] vel;
    logic       bounce;
  } axis_step_t;

  // Move pos by the signed velocity; clamp to [0, lim] and reverse on contact.
  function automatic axis_step_t axis_step(input coord_t pos,
                                           input logic signed [3:0] vel,
                                           input coord_t lim);
    logic signed [11:0] nx;
    logic signed [11:0] lim_s;
    axis_step_t         r;
    nx    = $signed({1'b0, pos}) + $signed({{8{vel[3]}}, vel});
    lim_s = $signed({1'b0, lim});
    r.pos    = nx[10:0];
    r.vel    = vel;
    r.bounce = 1'b0;
    if (nx < 12'sd0) begin
      r.pos    = '0;
      r.vel    = -vel;
      r.bounce = 1'b1;
    end else if (nx > lim_s) begin
      r.pos    = lim;
      r.vel    = -vel;
      r.bounce = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/anim_sprite_src.sv
// Sprite pixel source: multi-frame sprite RAM, address generation from the
// current pixel and sprite origin, one-cycle synchronous read and the
// matching hit/si_rgb pipeline, plus the final chroma-key/bypass mux.
// Optional ANIM_MIRROR_EN adds horizontal mirroring of the column address.
module anim_sprite_src
  import chu_video_pkg::*;
#(
  parameter int             CD         = 12,
  parameter int             ADDR_WIDTH = 12,
  parameter logic [CD-1:0]  KEY_COLOR  = '0,
  parameter int             SPR_W      = 32,
  parameter int             FR_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [10:0]           x0,
  input  logic [10:0]           y0,
  input  logic [FR_BITS-1:0]    frame_idx,
`ifdef ANIM_MIRROR_EN
  input  logic                  h_mirror,
`endif
  input  logic                  bypass,
  input  logic                  ram_we,
  input  logic [ADDR_WIDTH-1:0] ram_waddr,
  input  logic [CD-1:0]         ram_wdata,
  input  logic [CD-1:0]         si_rgb,
  output logic [CD-1:0]         so_rgb
);

  localparam int     SPR_BITS = $clog2(SPR_W);
  localparam coord_t SPR_W_C  = coord_t'(SPR_W);

  logic [CD-1:0]         ram [2**ADDR_WIDTH];
  coord_t                x_rel, y_rel;
  logic [SPR_BITS-1:0]   row, col;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  hit;
  logic                  hit_d;
  logic [CD-1:0]         si_rgb_d;
  logic [CD-1:0]         spr_rgb;

  // Relative position inside the sprite box and the RAM read address.
  // NOTE: every always_comb output gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    x_rel   = x - x0;
    y_rel   = y - y0;
    hit     = (x_rel < SPR_W_C) && (y_rel < SPR_W_C);
    row     = y_rel[SPR_BITS-1:0];
`ifdef ANIM_MIRROR_EN
    col     = h_mirror ? ~x_rel[SPR_BITS-1:0] : x_rel[SPR_BITS-1:0];
`else
    col     = x_rel[SPR_BITS-1:0];
`endif
    rd_addr = {frame_idx, row, col};
  end

  // Sprite RAM: CPU write port and synchronous pixel read port.
  // NOTE: the RAM and its read register have no reset so they map onto block
  // RAM; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    spr_rgb <= ram[rd_addr];
  end

  // Delay hit and upstream pixel to line up with the RAM read data.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d    <= 1'b0;
      si_rgb_d <= '0;
    end else begin
      hit_d    <= hit;
      si_rgb_d <= si_rgb;
    end
  end

  assign so_rgb = bypass                              ? si_rgb_d :
                  (hit_d && (spr_rgb != KEY_COLOR))   ? spr_rgb  : si_rgb_d;

endmodule

// File: rtl/chu_vga_sprite_anim_core.sv
// Animated, self-moving sprite stage for the video daisy chain.
// Registers, frame-tick logic, motion/bounce and frame animation live here;
// the pixel path is in anim_sprite_src. Position and velocity-driven moves
// commit only on the (0,0) frame tick so the sprite never tears.
// Optional feature: define ANIM_MIRROR_EN for ctrl bit7 horizontal mirror
// that toggles automatically on each horizontal bounce.
module chu_vga_sprite_anim_core
  import chu_video_pkg::*;
#(
  parameter int            CD         = 12,
  parameter int            ADDR_WIDTH = 12,
  parameter logic [CD-1:0] KEY_COLOR  = '0,
  parameter int            SPR_W      = 32,
  parameter int            NUM_FRAMES = 4,
  parameter int            H_MAX      = H_MAX_DEF,
  parameter int            V_MAX      = V_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int     FR_BITS = $clog2(NUM_FRAMES);
  localparam coord_t X_LIM   = coord_t'(H_MAX - SPR_W);
  localparam coord_t Y_LIM   = coord_t'(V_MAX - SPR_W);

  // Programmable state
  logic               bypass;
  coord_t             x0, y0;
  coord_t             x0_shadow, y0_shadow;
  logic               x_pend, y_pend;
  logic signed [3:0]  dx, dy;
  logic               anim_en, motion_en;
  logic [FR_BITS-1:0] frame_idx;
  logic [7:0]         anim_period;
  logic [7:0]         anim_cnt;
`ifdef ANIM_MIRROR_EN
  logic               h_mirror;
`endif

  // Bus decode
  logic wr_en, ram_we, reg_we;
  logic wr_bypass, wr_x0, wr_y0, wr_ctrl, wr_period, wr_vel;
  logic tick;
  logic unused_bits;

  assign wr_en     = cs & write;
  assign ram_we    = wr_en & ~addr[13];
  assign reg_we    = wr_en &  addr[13];
  assign wr_bypass = reg_we && (addr[2:0] == REG_BYPASS);
  assign wr_x0     = reg_we && (addr[2:0] == REG_X0);
  assign wr_y0     = reg_we && (addr[2:0] == REG_Y0);
  assign wr_ctrl   = reg_we && (addr[2:0] == REG_CTRL);
  assign wr_period = reg_we && (addr[2:0] == REG_PERIOD);
  assign wr_vel    = reg_we && (addr[2:0] == REG_VEL);
  assign tick      = (x == '0) && (y == '0);

  // Upper data bits and unused address bits carry no meaning here
  assign unused_bits = ^{wr_data, addr};

  // Next-state helpers for the tick: commit sources, motion step, anim wrap
  axis_step_t x_step, y_step;
  logic       x_commit, y_commit;
  coord_t     x_new, y_new;
  logic       anim_wrap;

  // Work out what each axis and the animation counter would do on a tick.
  always_comb begin
    x_step    = axis_step(x0, dx, X_LIM);
    y_step    = axis_step(y0, dy, Y_LIM);
    // A shadow write on the tick cycle itself counts as a write this frame
    x_commit  = x_pend | wr_x0;
    y_commit  = y_pend | wr_y0;
    x_new     = wr_x0 ? wr_data[10:0] : x0_shadow;
    y_new     = wr_y0 ? wr_data[10:0] : y0_shadow;
    anim_wrap = (anim_cnt == anim_period - 8'd1);
  end

  // Register file, tear-free position commit, motion/bounce and animation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bypass      <= 1'b1;
      x0          <= '0;
      y0          <= '0;
      x0_shadow   <= '0;
      y0_shadow   <= '0;
      x_pend      <= 1'b0;
      y_pend      <= 1'b0;
      dx          <= '0;
      dy          <= '0;
      anim_en     <= 1'b0;
      motion_en   <= 1'b0;
      frame_idx   <= '0;
      anim_period <= 8'd1;
      anim_cnt    <= '0;
`ifdef ANIM_MIRROR_EN
      h_mirror    <= 1'b0;
`endif
    end else begin
      if (wr_bypass) bypass <= wr_data[0];
      if (wr_period) anim_period <= (wr_data[7:0] == 8'd0) ? 8'd1 : wr_data[7:0];

      // x axis: CPU commit wins over motion; shadow tracks the live origin
      if (tick) begin
        x_pend <= 1'b0;
        if (x_commit) begin
          x0        <= x_new;
          x0_shadow <= x_new;
        end else if (motion_en) begin
          x0        <= x_step.pos;
          x0_shadow <= x_step.pos;
          if (x_step.bounce) dx <= x_step.vel;
`ifdef ANIM_MIRROR_EN
          // Face the new direction of travel after a horizontal bounce
          if (x_step.bounce) h_mirror <= ~h_mirror;
`endif
        end
      end else if (wr_x0) begin
        x0_shadow <= wr_data[10:0];
        x_pend    <= 1'b1;
      end

      // y axis: same rules as x
      if (tick) begin
        y_pend <= 1'b0;
        if (y_commit) begin
          y0        <= y_new;
          y0_shadow <= y_new;
        end else if (motion_en) begin
          y0        <= y_step.pos;
          y0_shadow <= y_step.pos;
          if (y_step.bounce) dy <= y_step.vel;
        end
      end else if (wr_y0) begin
        y0_shadow <= wr_data[10:0];
        y_pend    <= 1'b1;
      end

      // An explicit velocity write takes priority over a bounce reversal
      if (wr_vel) begin
        dx <= wr_data[3:0];
        dy <= wr_data[7:4];
      end

      // Animation: a ctrl write reloads the frame and overrides the step
      if (wr_ctrl) begin
        anim_en   <= wr_data[CTRL_ANIM_EN];
        motion_en <= wr_data[CTRL_MOTION_EN];
        frame_idx <= wr_data[CTRL_FRAME_LSB +: FR_BITS];
        anim_cnt  <= '0;
`ifdef ANIM_MIRROR_EN
        h_mirror  <= wr_data[CTRL_H_MIRROR];
`endif
      end else if (tick && anim_en) begin
        if (anim_wrap) begin
          anim_cnt  <= '0;
          frame_idx <= frame_idx + 1'b1;
        end else begin
          anim_cnt  <= anim_cnt + 8'd1;
        end
      end
    end
  end

  anim_sprite_src #(
    .CD         (CD),
    .ADDR_WIDTH (ADDR_WIDTH),
    .KEY_COLOR  (KEY_COLOR),
    .SPR_W      (SPR_W),
    .FR_BITS    (FR_BITS)
  ) u_src (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .x0        (x0),
    .y0        (y0),
    .frame_idx (frame_idx),
`ifdef ANIM_MIRROR_EN
    .h_mirror  (h_mirror),
`endif
    .bypass    (bypass),
    .ram_we    (ram_we),
    .ram_waddr (addr[ADDR_WIDTH-1:0]),
    .ram_wdata (wr_data[CD-1:0]),
    .si_rgb    (si_rgb),
    .so_rgb    (so_rgb)
  );

endmodule

// File: tb/tb_chu_vga_sprite_anim_core.sv
// Directed bench for chu_vga_sprite_anim_core: reset/bypass, static sprite
// box edges, chroma key, tear-free position update, animation stepping and
// wrap, period 0, ctrl write on the tick, motion with bounce on both axes,
// CPU write on the tick and asynchronous reset mid-operation.
module tb_chu_vga_sprite_anim_core;

  localparam logic [13:0] R_BYPASS = 14'h2000;
  localparam logic [13:0] R_X0     = 14'h2001;
  localparam logic [13:0] R_Y0     = 14'h2002;
  localparam logic [13:0] R_CTRL   = 14'h2003;
  localparam logic [13:0] R_PERIOD = 14'h2004;
  localparam logic [13:0] R_VEL    = 14'h2005;
  localparam logic [10:0] IDLE_X   = 11'd700;
  localparam logic [10:0] IDLE_Y   = 11'd500;
  localparam logic [11:0] BG       = 12'h555;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb, so_rgb;

  int errors = 0;
  int checks = 0;

  chu_vga_sprite_anim_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    x = '0; y = '0;
    @(posedge clk); #1;
    x = IDLE_X; y = IDLE_Y;
  endtask

  task automatic tick_wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    x = '0; y = '0;
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
    x = IDLE_X; y = IDLE_Y;
  endtask

  task automatic probe(input string tag, input logic [10:0] px, input logic [10:0] py,
                       input logic [11:0] si, input logic [11:0] exp);
    @(negedge clk);
    x = px; y = py; si_rgb = si;
    @(posedge clk); #1;
    check(tag, so_rgb, exp);
  endtask

  task automatic fill_frame(input logic [1:0] f, input logic [11:0] color);
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] off;
      off = i[9:0];
      wr({2'b00, f, off}, {20'd0, color});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    x = IDLE_X; y = IDLE_Y;
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    si_rgb = 12'h123;

    // Reset state: pipeline cleared, output 0
    #12;
    check("reset_out", so_rgb, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    probe("bypass_after_reset", IDLE_X, IDLE_Y, 12'hABC, 12'hABC);

    // Sprite RAM: frame 0 green with one key pixel at row 5 col 5
    fill_frame(2'd0, 12'h0F0);
    fill_frame(2'd1, 12'h002);
    fill_frame(2'd2, 12'h003);
    fill_frame(2'd3, 12'h004);
    wr({2'b00, 2'd0, 5'd5, 5'd5}, 32'h0);

    // Static sprite: shadow write is not visible until the tick
    wr(R_BYPASS, 32'h0);
    wr(R_X0, 32'd100);
    wr(R_Y0, 32'd50);
    probe("pos_before_tick", 11'd100, 11'd50, BG, BG);
    tick();
    probe("box_top_left",  11'd100, 11'd50, BG, 12'h0F0);
    probe("box_bot_right", 11'd131, 11'd81, BG, 12'h0F0);
    probe("left_of_box",   11'd99,  11'd50, BG, BG);
    probe("right_of_box",  11'd132, 11'd50, BG, BG);
    probe("below_box",     11'd100, 11'd82, BG, BG);
    probe("chroma_key",    11'd105, 11'd55, BG, BG);

    // Tear-free: mid-frame write keeps the old origin until the tick
    @(negedge clk); x = 11'd300; y = 11'd100;
    wr(R_X0, 32'd200);
    probe("old_pos_mid_frame", 11'd100, 11'd50, BG, 12'h0F0);
    probe("new_pos_not_yet",   11'd200, 11'd50, BG, BG);
    tick();
    probe("new_pos_after_tick", 11'd200, 11'd50, BG, 12'h0F0);
    probe("old_pos_gone",       11'd100, 11'd50, BG, BG);

    // Animation, period 3, frames 0x001..0x004
    fill_frame(2'd0, 12'h001);
    wr(R_PERIOD, 32'd3);
    wr(R_CTRL, 32'h1);
    probe("anim_start", 11'd200, 11'd50, BG, 12'h001);
    tick(); tick();
    probe("anim_hold_2_ticks", 11'd200, 11'd50, BG, 12'h001);
    tick();
    probe("anim_step_3rd_tick", 11'd200, 11'd50, BG, 12'h002);
    for (int i = 0; i < 6; i++) tick();
    probe("anim_frame3", 11'd200, 11'd50, BG, 12'h004);
    for (int i = 0; i < 3; i++) tick();
    probe("anim_wrap", 11'd200, 11'd50, BG, 12'h001);

    // Period 0 acts as 1: advance every tick
    wr(R_PERIOD, 32'd0);
    tick();
    probe("period0_tick1", 11'd200, 11'd50, BG, 12'h002);
    tick();
    probe("period0_tick2", 11'd200, 11'd50, BG, 12'h003);

    // ctrl write on the tick overrides the step (frame_sel=1)
    tick_wr(R_CTRL, 32'h5);
    probe("ctrl_on_tick", 11'd200, 11'd50, BG, 12'h002);
    wr(R_CTRL, 32'h0);
    tick();
    probe("anim_off_holds", 11'd200, 11'd50, BG, 12'h001);

    // Motion: dx=+7, dy=-3 from (600,1)
    wr(R_VEL, 32'h0000_00D7);
    wr(R_X0, 32'd600);
    wr(R_Y0, 32'd1);
    wr(R_CTRL, 32'h2);
    tick();
    probe("motion_commit_in",  11'd600, 11'd1, BG, 12'h001);
    probe("motion_commit_out", 11'd599, 11'd1, BG, BG);
    tick();
    probe("move_607_0_in",  11'd607, 11'd0, BG, 12'h001);
    probe("move_607_0_out", 11'd606, 11'd0, BG, BG);
    tick();
    probe("clamp_608_3_in",  11'd608, 11'd3, BG, 12'h001);
    probe("clamp_608_3_out", 11'd607, 11'd3, BG, BG);
    tick();
    probe("bounce_601_6_in",  11'd601, 11'd6, BG, 12'h001);
    probe("bounce_601_6_xout", 11'd600, 11'd6, BG, BG);
    probe("bounce_601_6_yout", 11'd601, 11'd5, BG, BG);

    // CPU write on the tick: x commits, x motion skipped, y still moves
    tick_wr(R_X0, 32'd300);
    probe("tick_write_in",  11'd300, 11'd9, BG, 12'h001);
    probe("tick_write_out", 11'd300, 11'd8, BG, BG);

    // Asynchronous reset mid-operation
    @(negedge clk);
    x = 11'd300; y = 11'd9; si_rgb = 12'h777;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_out", so_rgb, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    probe("reset_bypass", 11'd300, 11'd9, 12'h777, 12'h777);
    wr(R_BYPASS, 32'h0);
    probe("reset_origin_ram_kept", 11'd5,   11'd5, 12'h777, 12'h001);
    probe("reset_old_pos_gone",    11'd300, 11'd9, 12'h777, 12'h777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
